// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampled UART link (uart_tx / uart_rx).
// State encodings, parity/stop-bit modes and the per-bit oversampling length.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STARTBIT,
        S_FRAME,
        S_PARITY,
        S_STOP
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    localparam int unsigned STOP_ONE = 0;
    localparam int unsigned STOP_TWO = 1;

    localparam int unsigned BIT_LEN = 16;

    // Parity bit for a byte; any mode other than odd yields even parity.
    function automatic logic parity_bit(input logic [7:0] d, input int unsigned mode);
        return (mode == PAR_ODD) ? ~(^d) : ^d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake and serial-line bundle between a byte source and uart_tx.
interface uart_tx_if;

    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       done;

    modport master (
        output data,
        output valid,
        input  ready,
        input  tx,
        input  done
    );

    modport slave (
        input  data,
        input  valid,
        output ready,
        output tx,
        output done
    );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity, 1 or 2
// stop bits, each bit held for BIT_LEN clocks; back-to-back frames without gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned STOP_BIT = 0,
    parameter int unsigned PARITY   = 1
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus
);

    localparam bit         PAR_EN    = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
    localparam logic [2:0] LAST_STOP = (STOP_BIT != STOP_ONE) ? 3'd1 : 3'd0;
    localparam logic [3:0] LAST_TICK = 4'(BIT_LEN - 1);

    uart_state_e state;
    logic [3:0]  frame_count;
    logic [2:0]  bit_count;
    logic [7:0]  shreg;
    logic        par;
    logic        tx_q;
    logic        done_q;

    logic bit_end;
    logic last_stop;
    logic handshake;

    assign bit_end   = (frame_count == LAST_TICK);
    assign last_stop = (state == S_STOP) && (bit_count == LAST_STOP);
    assign bus.ready = rst && ((state == S_IDLE) || (last_stop && bit_end));
    assign handshake = bus.valid && bus.ready;

    assign bus.tx   = tx_q;
    assign bus.done = done_q;

    // tx and done are registered, so both are computed for the cycle being entered:
    // done looks one tick ahead so it lines up with the final stop-bit cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            frame_count <= '0;
            bit_count   <= '0;
            shreg       <= '0;
            par         <= 1'b0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            frame_count <= frame_count + 4'd1;
            done_q      <= last_stop && (frame_count == LAST_TICK - 4'd1);

            if (handshake) begin
                shreg       <= bus.data;
                par         <= parity_bit(bus.data, PARITY);
                state       <= S_STARTBIT;
                frame_count <= '0;
                bit_count   <= '0;
                tx_q        <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        frame_count <= '0;
                        tx_q        <= 1'b1;
                    end
                    S_STARTBIT: begin
                        if (bit_end) begin
                            state     <= S_FRAME;
                            bit_count <= '0;
                            tx_q      <= shreg[0];
                        end
                    end
                    S_FRAME: begin
                        if (bit_end) begin
                            shreg <= {1'b0, shreg[7:1]};
                            if (bit_count == 3'd7) begin
                                bit_count <= '0;
                                if (PAR_EN) begin
                                    state <= S_PARITY;
                                    tx_q  <= par;
                                end else begin
                                    state <= S_STOP;
                                    tx_q  <= 1'b1;
                                end
                            end else begin
                                bit_count <= bit_count + 3'd1;
                                tx_q      <= shreg[1];
                            end
                        end
                    end
                    S_PARITY: begin
                        if (bit_end) begin
                            state     <= S_STOP;
                            bit_count <= '0;
                            tx_q      <= 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (bit_end) begin
                            if (bit_count == LAST_STOP) begin
                                state <= S_IDLE;
                                tx_q  <= 1'b1;
                            end else begin
                                bit_count <= bit_count + 3'd1;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        tx_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

- Serial transmitter, the send side of the team's 16x-oversampled UART link.
- Accepts one byte per valid/ready handshake and shifts it out LSB-first on `tx`, framed as start bit, 8 data bits, optional parity bit and 1 or 2 stop bits.
- Each bit lasts exactly 16 `clk` cycles; `clk` runs at 16x the baud rate, so frames are directly receivable by `uart_rx` with matching parameters.

## Interface
- `STOP_BIT`, default 0: stop bits, 0 = 1 bit, 1 = 2 bits.
- `PARITY`, default 1: 1 = even parity (bit = XOR of data), 2 = odd parity (bit = inverted XOR), 0 = no parity bit.
- `clk` input 1: single clock, 16x baud rate.
- `rst` input 1: reset, synchronous, active-low.
- `data` input 8: byte to send; sampled only on handshake.
- `valid` input 1: `data` is valid; held until accepted.
- `ready` output 1: transmitter can accept a byte this cycle.
- `tx` output 1: serial line, idle high; registered output.
- `done` output 1: one-cycle pulse at the end of the last stop bit of each frame.

## Operation
- States:
  - IDLE: `tx` = 1.
  - START: `tx` = 0.
  - FRAME: `tx` = `shreg[0]`.
  - PARITY: `tx` = parity bit.
  - STOP: `tx` = 1.
- Internal registers:
  - 4-bit `frame_count`: cycle within the bit, counts 0..15; cleared in IDLE and on every handshake.
  - 3-bit `bit_count`: data or stop bit index.
  - 8-bit `shreg`: latched byte.
  - `par`: parity of the latched byte, computed at the handshake.
- Handshake: a byte is accepted on a rising edge where `rst`=1, `valid`=1 and `ready`=1. At that edge:
  - `shreg` is loaded with `data`, and `par` is computed (XOR for even, inverted XOR for odd).
  - The state moves to START and `frame_count` and `bit_count` are cleared.
- Transitions happen only at `frame_count`==15:
  - START → FRAME.
  - FRAME: `shreg` shifts right one bit; at `bit_count`==7 go to PARITY if `PARITY`≠0, else STOP.
  - PARITY → STOP.
  - STOP with `bit_count`==`STOP_BIT` → IDLE, or → START if a handshake occurs that cycle. Otherwise `bit_count` increments.
- `ready` = 1 in IDLE, and also in the final cycle of the last stop bit (STOP, `frame_count`==15, `bit_count`==`STOP_BIT`). This allows back-to-back frames with no idle gap. `ready` is 0 whenever `rst`=0.
- `done` pulses in that same final stop-bit cycle, whether or not a new byte is accepted.
- `valid` while `ready`=0 is ignored and is not queued. `data` changes while busy have no effect.
- `PARITY` values other than 0, 1 or 2 behave as 0.

## Timing
- Reset values (`rst`=0 at an edge): state IDLE, `tx`=1, `done`=0, counters 0, `shreg`=0. `ready`=0 while `rst`=0 and 1 on the first cycle after release.
- Reset mid-frame aborts the frame: `tx` is high from the reset edge, and no `done` pulse is produced.
- Latency: handshake at edge N → `tx`=0 during cycles N..N+15. Data bit k is driven during cycles N+16(k+1)..N+16(k+1)+15.
- Frame length is 16·(10 + (PARITY≠0) + STOP_BIT) cycles: 160, 176 or 192.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle, so `tx` has no glitch and no extra idle cycle.
- `done` is asserted for exactly one cycle per completed frame.

## Structure
- Shared package `uart_pkg`:
  - state encodings shared with `uart_rx` (IDLE, STARTBIT, FRAME, PARITY, STOP);
  - parity mode constants (NONE=0, EVEN=1, ODD=2);
  - stop-bit constants;
  - bit-length constant 16.
- No sub-module is needed; the block is a single FSM with its counters and shift register. The testbench instantiates `uart_rx` as the reference checker.

## Test plan
- 0x55, PARITY=1, STOP_BIT=0. Expected `tx` over 176 cycles: 0, then 1,0,1,0,1,0,1,0, then parity 0, then stop 1. `done` pulses at cycle N+175.
- 0x01, PARITY=2, STOP_BIT=1. Expected: start 0, data 1,0,0,0,0,0,0,0, parity 0, stop 1,1. Frame is 192 cycles.
- 0xA3, PARITY=0. Expected 160-cycle frame with no parity bit. Loopback to `uart_rx` (PARITY=0) gives `data`=0xA3 and `error`=0.
- Back-to-back 0x12 then 0x34, with `valid` held high:
  - `ready` is high only in the last stop-bit cycle;
  - the second start bit follows with zero gap;
  - `uart_rx` reports both bytes with no error.
- `rst` low at cycle N+50 of a 0xFF frame:
  - `tx`=1 from the next edge;
  - `ready`=0 during reset;
  - no `done` pulse;
  - after release, a new 0x0F frame is correct.
- `valid` pulsed with 0x99 at cycle N+20 while busy with 0x42: it is ignored, and only 0x42 appears on `tx`.
